serial_bla_subtractor: RTL

Multi-cycle unsigned subtractor computing D = A - B - Bin over a WIDTH-bit operand, four bits per clock. Each cycle uses a 4-bit borrow-look-ahead slice, the subtracting counterpart of the team's 4-bit carry-look-ahead adder. The nibble borrow is registered between cycles. Sits beside the adder in the arithmetic datapath and trades latency for a single narrow slice, using a start/busy/done handshake.

---
 rtl/arith_pkg.sv | 16 +
 rtl/bla_sub4.sv | 30 +++
 rtl/serial_bla_subtractor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: handshake FSM states and slice geometry.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int calc_nib(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/bla_sub4.sv
// Combinational 4-bit borrow-look-ahead subtractor slice: d = a - b - bin.
module bla_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic       b1_s;
    logic       b2_s;
    logic       b3_s;

    assign g_s = ~a & b;
    assign p_s = ~(a ^ b);

    // Every borrow is flattened to generate/propagate terms so no bit waits on its neighbour.
    assign b1_s = g_s[0] | (p_s[0] & bin);
    assign b2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
    assign b3_s = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & bin);
    assign bout = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & bin);

    assign d = a ^ b ^ {b3_s, b2_s, b1_s, bin};

endmodule

// File: rtl/serial_bla_subtractor.sv
// Multi-cycle unsigned subtractor D = A - B - Bin, one nibble per clock through a
// single borrow-look-ahead slice, with a start/busy/done handshake.
module serial_bla_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic [WIDTH:0]   out
);

    localparam int NIB = calc_nib(WIDTH);
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int IW  = KW + 2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IW-1:0]    base_s;
    logic [3:0]       slice_d_s;
    logic             slice_bout_s;

    assign base_s = {k_q, 2'b00};

    bla_sub4 u_slice (
        .a    (a_q[base_s +: SLICE_W]),
        .b    (b_q[base_s +: SLICE_W]),
        .bin  (brw_q),
        .d    (slice_d_s),
        .bout (slice_bout_s)
    );

    // Handshake FSM and per-nibble datapath next-state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        brw_d   = brw_q;
        d_d     = d_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    k_d     = '0;
                    d_d     = '0;
                    bout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                d_d[base_s +: SLICE_W] = slice_d_s;
                brw_d                  = slice_bout_s;
                if (k_q == KW'(NIB - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    bout_d  = slice_bout_s;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, operand, borrow and result registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            brw_q   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            brw_q   <= brw_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
    assign out  = {bout_q, d_q};

endmodule
